// File: rtl/uart_block_assembler.sv
// Packs UART bytes into a BLOCK_BYTES-wide block, first byte in the top byte,
// and holds the block on a valid/ready handshake until the consumer takes it.
module uart_block_assembler #(
    parameter int BLOCK_BYTES    = 16,
    parameter int TIMEOUT_CYCLES = 208_334
) (
    input  logic                               clock_fpga,
    input  logic                               reset,
    input  logic [7:0]                         rx_data,
    input  logic                               rx_valid,
    output logic [8*BLOCK_BYTES-1:0]           block_data,
    output logic                               block_valid,
    input  logic                               block_ready,
    output logic [$clog2(BLOCK_BYTES+1)-1:0]   byte_count,
    output logic                               overrun,
    output logic                               timeout_err,
    output logic                               dbg_state
);
    localparam int W  = 8 * BLOCK_BYTES;
    localparam int CW = $clog2(BLOCK_BYTES + 1);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_BYTE = CW'(BLOCK_BYTES - 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT_CYCLES - 1);

    // Handshake: block_data is transferred on a rising clock_fpga edge where
    // block_valid & block_ready are both high; block_valid never drops before that.
    typedef enum logic {S_COLLECT = 1'b0, S_HOLD = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    data_q, data_d;
    logic            valid_q, valid_d;
    logic [CW-1:0]   count_q, count_d;
    logic [IW-1:0]   idle_q, idle_d;
    logic            overrun_q, overrun_d;
    logic            timeout_q, timeout_d;

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        valid_d   = valid_q;
        count_d   = count_q;
        idle_d    = idle_q;
        overrun_d = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            S_COLLECT: begin
                if (rx_valid) begin
                    data_d  = {data_q[W-9:0], rx_data};
                    count_d = count_q + CW'(1);
                    idle_d  = '0;
                    if (count_q == LAST_BYTE) begin
                        state_d = S_HOLD;
                        valid_d = 1'b1;
                    end
                end else if (count_q != '0) begin
                    // A stalled partial block is thrown away so a resync starts clean.
                    if (idle_q == IDLE_MAX) begin
                        count_d   = '0;
                        data_d    = '0;
                        idle_d    = '0;
                        timeout_d = 1'b1;
                    end else begin
                        idle_d = idle_q + IW'(1);
                    end
                end else begin
                    idle_d = '0;
                end
            end
            S_HOLD: begin
                idle_d = '0;
                if (block_ready) begin
                    state_d = S_COLLECT;
                    valid_d = 1'b0;
                    data_d  = '0;
                    count_d = '0;
                    if (rx_valid) begin
                        data_d[7:0] = rx_data;
                        count_d     = CW'(1);
                    end
                end else if (rx_valid) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = S_COLLECT;
        endcase
    end

    always_ff @(posedge clock_fpga or posedge reset) begin
        if (reset) begin
            state_q   <= S_COLLECT;
            data_q    <= '0;
            valid_q   <= 1'b0;
            count_q   <= '0;
            idle_q    <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            count_q   <= count_d;
            idle_q    <= idle_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    assign block_data  = data_q;
    assign block_valid = valid_q;
    assign byte_count  = count_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_q;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_uart_block_assembler.sv
// Randomized and directed bench for uart_block_assembler, checked cycle by cycle
// against a byte-queue reference model through an expected-value queue.
module tb_uart_block_assembler;
    localparam int NB = 16;
    localparam int TO = 50;
    localparam int W  = 8 * NB;
    localparam int CW = $clog2(NB + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          block_ready = 1'b0;
    logic [W-1:0]  block_data;
    logic          block_valid;
    logic [CW-1:0] byte_count;
    logic          overrun;
    logic          timeout_err;
    logic          dbg_state;

    uart_block_assembler #(.BLOCK_BYTES(NB), .TIMEOUT_CYCLES(TO)) dut (
        .clock_fpga (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .block_data (block_data),
        .block_valid(block_valid),
        .block_ready(block_ready),
        .byte_count (byte_count),
        .overrun    (overrun),
        .timeout_err(timeout_err),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          v;
        logic [CW-1:0] c;
        logic          o;
        logic          t;
        logic [W-1:0]  d;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: bytes of the block being built, held block, idle run.
    logic [7:0]   cur[$];
    logic         held = 1'b0;
    logic [W-1:0] held_blk = '0;
    int           idle = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        cur.delete();
        held = 1'b0;
        held_blk = '0;
        idle = 0;
    endtask

    // One clock of stimulus; the model predicts the outputs after the next edge.
    task automatic drive(input logic v, input logic [7:0] d, input logic r);
        exp_t x;
        @(negedge clk);
        rx_valid    = v;
        rx_data     = d;
        block_ready = r;
        x = '0;
        if (held) begin
            idle = 0;
            if (r) begin
                held = 1'b0;
                cur.delete();
                if (v) cur.push_back(d);
            end else if (v) begin
                x.o = 1'b1;
            end
        end else if (v) begin
            cur.push_back(d);
            idle = 0;
            if (cur.size() == NB) begin
                held = 1'b1;
                held_blk = '0;
                for (int i = 0; i < NB; i++) held_blk[W-1-8*i -: 8] = cur[i];
                cur.delete();
            end
        end else if (cur.size() > 0) begin
            idle++;
            if (idle == TO) begin
                x.t = 1'b1;
                idle = 0;
                cur.delete();
            end
        end
        x.v = held;
        x.c = held ? CW'(NB) : CW'(cur.size());
        x.d = held_blk;
        exp_q.push_back(x);
    endtask

    task automatic send_block(input logic [7:0] first, input logic r);
        for (int i = 0; i < NB; i++) drive(1'b1, first + 8'(i), r);
    endtask

    task automatic idle_cycles(input int n, input logic r);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, r);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_data"},    block_data, '0);
        chk({tag, "_valid"},   W'(block_valid), '0);
        chk({tag, "_count"},   W'(byte_count), '0);
        chk({tag, "_overrun"}, W'(overrun), '0);
        chk({tag, "_timeout"}, W'(timeout_err), '0);
    endtask

    // Asserts reset between edges and checks outputs before any clock edge.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #3;
        rx_valid = 1'b0;
        block_ready = 1'b0;
        reset = 1'b1;
        #1;
        check_reset_outputs(tag);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("block_valid", W'(block_valid), W'(e.v));
                chk("byte_count",  W'(byte_count),  W'(e.c));
                chk("overrun",     W'(overrun),     W'(e.o));
                chk("timeout_err", W'(timeout_err), W'(e.t));
                chk("dbg_state",   W'(dbg_state),   W'(e.v));
                if (e.v) chk("block_data", block_data, e.d);
            end
        end
    end

    initial begin
        logic [W-1:0] ramp;
        #22;
        check_reset_outputs("por");
        @(negedge clk);
        reset = 1'b0;

        // Ramp 0x00..0x0F with ready high, then handshake.
        send_block(8'h00, 1'b1);
        ramp = 128'h000102030405060708090A0B0C0D0E0F;
        @(posedge clk);
        #2;
        chk("ramp_block", block_data, ramp);
        idle_cycles(2, 1'b1);

        // Held block, dropped byte, late ready.
        send_block(8'h20, 1'b0);
        drive(1'b1, 8'hAA, 1'b0);
        idle_cycles(3, 1'b0);
        idle_cycles(1, 1'b1);
        idle_cycles(2, 1'b0);

        // Byte on the handshake cycle starts the next block.
        send_block(8'h40, 1'b0);
        drive(1'b1, 8'h55, 1'b1);
        for (int i = 1; i < NB; i++) drive(1'b1, 8'(8'h60 + i), 1'b0);
        idle_cycles(1, 1'b1);

        // Timeout of a 5-byte partial, then a fresh block.
        for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h80 + i), 1'b0);
        idle_cycles(TO + 2, 1'b0);
        send_block(8'h90, 1'b0);
        idle_cycles(1, 1'b1);

        // Byte arriving exactly on the timeout cycle wins.
        for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'hB0 + i), 1'b0);
        idle_cycles(TO - 1, 1'b0);
        drive(1'b1, 8'hC5, 1'b0);
        idle_cycles(TO + 1, 1'b0);

        // Asynchronous reset mid-HOLD and mid-COLLECT.
        send_block(8'hD0, 1'b0);
        idle_cycles(2, 1'b0);
        async_reset("rst_hold");
        for (int i = 0; i < 7; i++) drive(1'b1, 8'(8'hE0 + i), 1'b0);
        async_reset("rst_collect");
        send_block(8'hF0, 1'b1);
        idle_cycles(1, 1'b1);

        // Randomized traffic with occasional long idle gaps.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) < 3) begin
                idle_cycles($urandom_range(TO - 10, TO + 10), 1'($urandom_range(0, 1)));
            end else begin
                drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                      1'($urandom_range(0, 3) == 0));
            end
        end
        idle_cycles(2, 1'b1);

        @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
